fp_accum_seq: RTL and testbench

Sequencer that sits directly upstream and downstream of the combinational FP32 add/subtract stage. It streams FP32 elements in over a valid/ready interface and drives the adder operands each cycle. It registers the adder result as a running accumulator. On the last element it presents the final sum on a valid/ready output. It is used for vector reductions (vfredsum-style) in the coprocessor datapath.

---
 rtl/fp_pkg.sv | 28 ++
 rtl/fp_accum_seq_if.sv | 41 ++++
 rtl/fp_accum_seq.sv | 96 +++++++++
 tb/tb_fp_accum_seq.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// FP32 field/constant definitions and sequencer state encoding shared by the
// accumulate sequencer, its interface and the surrounding datapath.
package fp_pkg;

  localparam int SIGN_BIT = 31;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 23;
  localparam int FRAC_W   = 23;
  localparam logic [7:0] EXP_ALL_ONES = 8'hFF;

  localparam logic [31:0] FP_QNAN    = 32'h7fc00000;
  localparam logic [31:0] FP_POS_INF = 32'h7f800000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic logic fp_is_inf(input logic [31:0] v);
    return (v[EXP_MSB:EXP_LSB] == EXP_ALL_ONES) && (v[FRAC_W-1:0] == '0);
  endfunction

  function automatic logic fp_is_nan(input logic [31:0] v);
    return (v[EXP_MSB:EXP_LSB] == EXP_ALL_ONES) && (v[FRAC_W-1:0] != '0);
  endfunction

endpackage

// File: rtl/fp_accum_seq_if.sv
// Element stream, adder operand/result and result handshake of fp_accum_seq.
// out_status exists only when FP_ACCUM_STATUS_EN is defined.
interface fp_accum_seq_if #(parameter int CNT_W = 8);

  logic             start;
  logic [31:0]      seed;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_data;
  logic             in_sub;
  logic             in_last;
  logic [31:0]      add_a;
  logic [31:0]      add_b;
  logic             add_sub;
  logic [31:0]      add_y;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic [CNT_W-1:0] out_count;
  logic             busy;
`ifdef FP_ACCUM_STATUS_EN
  logic [1:0]       out_status;
`endif

  modport slave (
    input  start, seed, in_valid, in_data, in_sub, in_last, add_y, out_ready,
`ifdef FP_ACCUM_STATUS_EN
    output out_status,
`endif
    output in_ready, add_a, add_b, add_sub, out_valid, out_data, out_count, busy
  );

  modport master (
    output start, seed, in_valid, in_data, in_sub, in_last, add_y, out_ready,
`ifdef FP_ACCUM_STATUS_EN
    input  out_status,
`endif
    input  in_ready, add_a, add_b, add_sub, out_valid, out_data, out_count, busy
  );

endinterface

// File: rtl/fp_accum_seq.sv
// FP32 reduction sequencer around an external adder; FP_ACCUM_STATUS_EN adds sticky inf/nan status.
// Latency: accepted element updates acc next cycle; result valid the cycle after the last element.
// Backpressure: in_ready only in ACCUM; result held in DONE until out_ready.
module fp_accum_seq
  import fp_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic clk,
  input  logic reset,
  fp_accum_seq_if.slave bus
);

  state_t           state_q, state_d;
  logic [31:0]      acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_ready;
  logic             out_valid;
  logic             accept;

  assign accept = in_ready && bus.in_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          acc_d   = bus.seed;
          cnt_d   = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          acc_d = bus.add_y;
          // Count sticks at all ones once it saturates.
          cnt_d = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
          if (bus.in_last) state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef FP_ACCUM_STATUS_EN
  logic [1:0] status_q, status_d;

  always_ff @(posedge clk) begin
    if (reset) status_q <= '0;
    else       status_q <= status_d;
  end

  always_comb begin
    status_d = status_q;
    if (state_q == IDLE && bus.start) begin
      status_d = '0;
    end else if (accept) begin
      status_d[0] = status_q[0] | fp_is_inf(bus.add_y);
      status_d[1] = status_q[1] | fp_is_nan(bus.add_y);
    end
  end

  assign bus.out_status = status_q;
`endif

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = acc_q;
  assign bus.out_count = cnt_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.add_a     = acc_q;
  assign bus.add_b     = bus.in_data;
  assign bus.add_sub   = bus.in_sub;

endmodule

// File: tb/tb_fp_accum_seq.sv
// Bench for fp_accum_seq: two instances (CNT_W=8 and CNT_W=2) share stimulus,
// each with a behavioural FP32 adder and its own expected-result queue.
module tb_fp_accum_seq;
  import fp_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] seed = '0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_sub = 1'b0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  cnt;
    logic [1:0]  st;
  } exp_t;
  exp_t qa[$];
  exp_t qb[$];

  always #5 clk = ~clk;

  fp_accum_seq_if #(.CNT_W(8)) ifa ();
  fp_accum_seq_if #(.CNT_W(2)) ifb ();

  assign ifa.start = start;     assign ifb.start = start;
  assign ifa.seed = seed;       assign ifb.seed = seed;
  assign ifa.in_valid = in_valid; assign ifb.in_valid = in_valid;
  assign ifa.in_data = in_data; assign ifb.in_data = in_data;
  assign ifa.in_sub = in_sub;   assign ifb.in_sub = in_sub;
  assign ifa.in_last = in_last; assign ifb.in_last = in_last;
  assign ifa.out_ready = out_ready; assign ifb.out_ready = out_ready;

  fp_accum_seq #(.CNT_W(8)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
  fp_accum_seq #(.CNT_W(2)) dut_b (.clk(clk), .reset(reset), .bus(ifb));

  // Behavioural FP32 adder via double precision (denormals flushed to zero).
  function automatic logic [63:0] f2d(input logic [31:0] f);
    logic [10:0] e11;
    if (f[30:23] == 8'h00) return {f[31], 63'b0};
    if (f[30:23] == 8'hFF) return {f[31], 11'h7FF, f[22:0], 29'b0};
    e11 = {3'b0, f[30:23]} + 11'd896;
    return {f[31], e11, f[22:0], 29'b0};
  endfunction

  function automatic logic [31:0] d2f(input logic [63:0] d);
    logic [10:0] e11;
    e11 = d[62:52];
    if (e11 == 11'h000) return {d[63], 31'b0};
    if (e11 == 11'h7FF) return (d[51:0] != '0) ? FP_QNAN : {d[63], 8'hFF, 23'b0};
    e11 = e11 - 11'd896;
    return {d[63], e11[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] fpadd(input logic [31:0] a, input logic [31:0] b, input logic s);
    real ra, rb;
    ra = $bitstoreal(f2d(a));
    rb = $bitstoreal(f2d(b));
    return d2f($realtobits(s ? ra - rb : ra + rb));
  endfunction

  always_comb ifa.add_y = fpadd(ifa.add_a, ifa.add_b, ifa.add_sub);
  always_comb ifb.add_y = fpadd(ifb.add_a, ifb.add_b, ifb.add_sub);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic expect_res(input logic [31:0] d, input logic [7:0] ca, input logic [7:0] cb,
                            input logic [1:0] st);
    qa.push_back('{data: d, cnt: ca, st: st});
    qb.push_back('{data: d, cnt: cb, st: st});
  endtask

  task automatic begin_red(input logic [31:0] s);
    start = 1'b1;
    seed  = s;
    @(posedge clk); #1;
    start = 1'b0;
    chk("in_ready_accum_a", {31'b0, ifa.in_ready}, 32'd1);
    chk("in_ready_accum_b", {31'b0, ifb.in_ready}, 32'd1);
    chk("seed_on_add_a", ifa.add_a, s);
  endtask

  task automatic feed(input logic [31:0] d, input logic s, input logic l);
    in_valid = 1'b1;
    in_data  = d;
    in_sub   = s;
    in_last  = l;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic to_idle();
    @(posedge clk); #1;
    chk("out_valid_dropped", {31'b0, ifa.out_valid}, 32'd0);
    chk("busy_idle", {31'b0, ifa.busy}, 32'd0);
  endtask

  task automatic monitor_one();
    exp_t e;
    if (ifa.out_valid) begin
      if (qa.size() == 0) chk("unexpected_out_a", 32'd1, 32'd0);
      else begin
        e = qa.pop_front();
        chk("out_data_a", ifa.out_data, e.data);
        chk("out_count_a", 32'(ifa.out_count), 32'(e.cnt));
`ifdef FP_ACCUM_STATUS_EN
        chk("out_status_a", 32'(ifa.out_status), 32'(e.st));
`endif
      end
    end
    if (ifb.out_valid) begin
      if (qb.size() == 0) chk("unexpected_out_b", 32'd1, 32'd0);
      else begin
        e = qb.pop_front();
        chk("out_data_b", ifb.out_data, e.data);
        chk("out_count_b", 32'(ifb.out_count), 32'(e.cnt));
`ifdef FP_ACCUM_STATUS_EN
        chk("out_status_b", 32'(ifb.out_status), 32'(e.st));
`endif
      end
    end
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (!reset && out_ready) monitor_one();
      end
      begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
      end
      begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'b0, ifa.out_valid}, 32'd0);
        chk("rst_in_ready", {31'b0, ifa.in_ready}, 32'd0);
        chk("rst_busy", {31'b0, ifa.busy}, 32'd0);
        chk("rst_out_data", ifa.out_data, 32'd0);
        chk("rst_out_count", 32'(ifa.out_count), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // 0 + 1 + 2 + 3 = 6; start during the DONE handshake must be ignored
        begin_red(32'h00000000);
        feed(32'h3f800000, 1'b0, 1'b0);
        feed(32'h40000000, 1'b0, 1'b0);
        feed(32'h40400000, 1'b0, 1'b1);
        expect_res(32'h40c00000, 8'd3, 8'd3, 2'b00);
        chk("busy_done", {31'b0, ifa.busy}, 32'd1);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("start_in_done_ignored", {31'b0, ifa.in_ready}, 32'd0);
        chk("busy_after_done", {31'b0, ifa.busy}, 32'd0);

        // 5 - 2 = 3
        begin_red(32'h40a00000);
        feed(32'h40000000, 1'b1, 1'b1);
        expect_res(32'h40400000, 8'd1, 8'd1, 2'b00);
        to_idle();

        // Backpressure: result held for 5 cycles, start in that window ignored
        out_ready = 1'b0;
        begin_red(32'h3f800000);
        feed(32'h3f800000, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
          start = (i == 2);
          @(negedge clk);
          chk("bp_out_valid", {31'b0, ifa.out_valid}, 32'd1);
          chk("bp_out_data", ifa.out_data, 32'h40000000);
          chk("bp_in_ready", {31'b0, ifa.in_ready}, 32'd0);
          @(posedge clk); #1;
        end
        start = 1'b0;
        expect_res(32'h40000000, 8'd1, 8'd1, 2'b00);
        out_ready = 1'b1;
        to_idle();
        chk("bp_in_ready_idle", {31'b0, ifa.in_ready}, 32'd0);

        // Reset after 2 of 4 elements, then a clean 3 + 4*1 = 7
        begin_red(32'h00000000);
        feed(32'h3f800000, 1'b0, 1'b0);
        feed(32'h3f800000, 1'b0, 1'b0);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("midrst_out_valid", {31'b0, ifa.out_valid}, 32'd0);
        chk("midrst_in_ready", {31'b0, ifa.in_ready}, 32'd0);
        chk("midrst_out_count", 32'(ifa.out_count), 32'd0);
        chk("midrst_busy", {31'b0, ifb.busy}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        begin_red(32'h40400000);
        for (int i = 0; i < 4; i++) feed(32'h3f800000, 1'b0, i == 3);
        expect_res(32'h40e00000, 8'd4, 8'd3, 2'b00);
        to_idle();

        // Six elements: CNT_W=2 instance saturates at 3
        begin_red(32'h00000000);
        for (int i = 0; i < 6; i++) feed(32'h3f800000, 1'b0, i == 5);
        expect_res(32'h40c00000, 8'd6, 8'd3, 2'b00);
        to_idle();

        // inf + 1 = inf (sticky-inf), then a clean reduction clears status
        begin_red(FP_POS_INF);
        feed(32'h3f800000, 1'b0, 1'b1);
        expect_res(FP_POS_INF, 8'd1, 8'd1, 2'b01);
        to_idle();
        begin_red(32'h00000000);
        feed(32'h3f800000, 1'b0, 1'b1);
        expect_res(32'h3f800000, 8'd1, 8'd1, 2'b00);
        to_idle();

        // NaN + 1 = NaN (sticky-nan)
        begin_red(FP_QNAN);
        feed(32'h3f800000, 1'b0, 1'b1);
        expect_res(FP_QNAN, 8'd1, 8'd1, 2'b10);
        to_idle();

        repeat (2) @(posedge clk);
        #1;
        chk("qa_drained", qa.size(), 32'd0);
        chk("qb_drained", qb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
      end
    join
  end

endmodule
